// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: forms RV32I/RV64I immediates and presents them through a 2-entry skid buffer.
// Build option: define IMMGEN_ILLEGAL_TRAP_EN to flag sel 111 as illegal (imm 0) instead of emitting a poison pattern.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [24:0]      instr_i,
  input  logic [2:0]       imm_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [2:0] SEL_I     = 3'b000;
  localparam logic [2:0] SEL_S     = 3'b001;
  localparam logic [2:0] SEL_B     = 3'b010;
  localparam logic [2:0] SEL_J     = 3'b011;
  localparam logic [2:0] SEL_U     = 3'b100;
  localparam logic [2:0] SEL_SHAMT = 3'b101;
  localparam logic [2:0] SEL_ZIMM  = 3'b110;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  // instr_i[k] carries instruction bit k+7
  logic [11:0] imm_i12;
  logic [11:0] imm_s12;
  logic [12:0] imm_b13;
  logic [20:0] imm_j21;
  logic [31:0] imm_u32;

  assign imm_i12 = instr_i[24:13];
  assign imm_s12 = {instr_i[24:18], instr_i[4:0]};
  assign imm_b13 = {instr_i[24], instr_i[0], instr_i[23:18], instr_i[4:1], 1'b0};
  assign imm_j21 = {instr_i[24], instr_i[12:5], instr_i[13], instr_i[23:14], 1'b0};
  assign imm_u32 = {instr_i[24:5], 12'b0};

  entry_t new_c;

  // Immediate formation ahead of the buffer register
  always_comb begin
    new_c         = '0;
    new_c.tag     = tag_i;
    new_c.illegal = 1'b0;
    case (imm_sel_i)
      SEL_I:     new_c.imm = XLEN'($signed(imm_i12));
      SEL_S:     new_c.imm = XLEN'($signed(imm_s12));
      SEL_B:     new_c.imm = XLEN'($signed(imm_b13));
      SEL_J:     new_c.imm = XLEN'($signed(imm_j21));
      SEL_U:     new_c.imm = XLEN'($signed(imm_u32));
      SEL_SHAMT: new_c.imm = XLEN'(instr_i[13+SHW-1:13]);
      SEL_ZIMM:  new_c.imm = XLEN'(instr_i[12:8]);
      default: begin
`ifdef IMMGEN_ILLEGAL_TRAP_EN
        new_c.imm     = '0;
        new_c.illegal = 1'b1;
`else
        new_c.imm     = XLEN'($signed(32'hDEAD_BEEF));
        new_c.illegal = 1'b0;
`endif
      end
    endcase
  end

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_v_q, main_v_d;
  logic   skid_v_q, skid_v_d;
  logic   accept_c;
  logic   drain_c;

  assign accept_c = in_valid_i && !skid_v_q;
  assign drain_c  = main_v_q && out_ready_i;

  // Buffer next-state: skid refills main on drain; new entries land in main when it frees up
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (drain_c) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          main_v_d = 1'b1;
          skid_v_d = 1'b0;
        end else begin
          main_v_d = 1'b0;
        end
      end
      if (accept_c) begin
        if (!main_v_q || drain_c) begin
          main_d   = new_c;
          main_v_d = 1'b1;
        end else begin
          skid_d   = new_c;
          skid_v_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign in_ready_o  = !skid_v_q;
  assign out_valid_o = main_v_q;
  assign imm_o       = main_q.imm;
  assign tag_o       = main_q.tag;
  assign illegal_o   = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 instance for formats/handshake, XLEN=64 instance for wide forms.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] instr;
  logic [2:0]  sel;
  logic [7:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm;
  logic [7:0]  tag_out;
  logic        illegal;

  logic        flush64;
  logic        in_valid64;
  logic        in_ready64;
  logic [24:0] instr64;
  logic [2:0]  sel64;
  logic [7:0]  tag64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] imm64;
  logic [7:0]  tag_out64;
  logic        illegal64;

  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .imm_sel_i(sel), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .imm_o(imm), .tag_o(tag_out), .illegal_o(illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush64),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64),
    .instr_i(instr64), .imm_sel_i(sel64), .tag_i(tag64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64),
    .imm_o(imm64), .tag_o(tag_out64), .illegal_o(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] s, input logic [7:0] t);
    in_valid = 1'b1;
    instr    = ins[31:7];
    sel      = s;
    tag      = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; sel = '0; tag = '0; out_ready = 1'b1;
    flush64 = 1'b0; in_valid64 = 1'b0; instr64 = '0; sel64 = '0; tag64 = '0; out_ready64 = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (imm !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", imm); end
    total++; if (tag_out !== 8'h0) begin bad++; $display("FAIL rst_tag got=%h exp=0", tag_out); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b exp=0", illegal); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_formats();
    logic [31:0] ins_t [7];
    logic [2:0]  sel_t [7];
    logic [31:0] exp_t [7];
    ins_t = '{32'hFFF00093, 32'hFE000E23, 32'hFE000EE3, 32'h800000EF, 32'h123450B7, 32'h03F09093, 32'h000FD073};
    sel_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    exp_t = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFF00000, 32'h12345000, 32'h0000001F, 32'h0000001F};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(ins_t[k], sel_t[k], 8'h5A + 8'(k));
      cyc();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fmt%0d_valid got=%b exp=1", k, out_valid); end
      total++; if (imm !== exp_t[k]) begin bad++; $display("FAIL fmt%0d_imm got=%h exp=%h", k, imm, exp_t[k]); end
      total++; if (tag_out !== 8'h5A + 8'(k)) begin bad++; $display("FAIL fmt%0d_tag got=%h exp=%h", k, tag_out, 8'h5A + 8'(k)); end
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fmt%0d_drained got=%b exp=0", k, out_valid); end
    end
    drive(32'h00000000, 3'b111, 8'hEE);
    cyc();
    in_valid = 1'b0;
`ifdef IMMGEN_ILLEGAL_TRAP_EN
    total++; if (imm !== 32'h0) begin bad++; $display("FAIL ill32_imm got=%h exp=0", imm); end
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill32_flag got=%b exp=1", illegal); end
`else
    total++; if (imm !== 32'hDEADBEEF) begin bad++; $display("FAIL ill32_imm got=%h exp=deadbeef", imm); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill32_flag got=%b exp=0", illegal); end
`endif
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins_t [4];
    logic [2:0]  sel_t [4];
    logic [31:0] exp_t [4];
    ins_t = '{32'hFE000EE3, 32'h123450B7, 32'h00509093, 32'h000FD073};
    sel_t = '{3'd2, 3'd4, 3'd5, 3'd6};
    exp_t = '{32'hFFFFFFFC, 32'h12345000, 32'h00000005, 32'h0000001F};
    out_ready = 1'b1;
    drive(ins_t[0], sel_t[0], 8'h10);
    cyc();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(ins_t[k+1], sel_t[k+1], 8'h11 + 8'(k));
      else in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || imm !== exp_t[k] || tag_out !== 8'h10 + 8'(k))
        begin bad++; $display("FAIL b2b%0d got v=%b imm=%h tag=%h exp v=1 imm=%h tag=%h", k, out_valid, imm, tag_out, exp_t[k], 8'h10 + 8'(k)); end
      cyc();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd0, 8'd1);
    cyc();
    total++; if (in_ready !== 1'b1 || tag_out !== 8'd1) begin bad++; $display("FAIL bp_first got rdy=%b tag=%0d exp rdy=1 tag=1", in_ready, tag_out); end
    tag = 8'd2;
    cyc();
    total++; if (in_ready !== 1'b0 || tag_out !== 8'd1) begin bad++; $display("FAIL bp_full got rdy=%b tag=%0d exp rdy=0 tag=1", in_ready, tag_out); end
    tag = 8'd3;
    cyc();
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || tag_out !== 8'd1) begin bad++; $display("FAIL bp_hold got rdy=%b v=%b tag=%0d exp rdy=0 v=1 tag=1", in_ready, out_valid, tag_out); end
    out_ready = 1'b1;
    cyc();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || tag_out !== 8'd2) begin bad++; $display("FAIL bp_rel2 got rdy=%b v=%b tag=%0d exp rdy=1 v=1 tag=2", in_ready, out_valid, tag_out); end
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || tag_out !== 8'd3) begin bad++; $display("FAIL bp_rel3 got v=%b tag=%0d exp v=1 tag=3", out_valid, tag_out); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd0, 8'h11);
    cyc();
    tag = 8'h22;
    cyc();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_full got rdy=%b exp=0", in_ready); end
    tag = 8'h33; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL fl_both got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    // main-only case: in_ready is high, so the offered entry must be dropped by flush
    drive(32'hFFF00093, 3'd0, 8'h44);
    cyc();
    tag = 8'h55; flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL fl_main got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_noghost got v=%b tag=%h exp v=0", out_valid, tag_out); end
  endtask

  task automatic test_xlen64();
    logic [31:0] ins_t [4];
    logic [2:0]  sel_t [4];
    logic [63:0] exp_t [4];
    ins_t = '{32'h80000013, 32'h03F09093, 32'h800000B7, 32'h00000000};
    sel_t = '{3'd0, 3'd5, 3'd4, 3'd7};
`ifdef IMMGEN_ILLEGAL_TRAP_EN
    exp_t = '{64'hFFFFFFFFFFFFF800, 64'h3F, 64'hFFFFFFFF80000000, 64'h0};
`else
    exp_t = '{64'hFFFFFFFFFFFFF800, 64'h3F, 64'hFFFFFFFF80000000, 64'hFFFFFFFFDEADBEEF};
`endif
    out_ready64 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid64 = 1'b1; instr64 = ins_t[k][31:7]; sel64 = sel_t[k]; tag64 = 8'hA0 + 8'(k);
      cyc();
      in_valid64 = 1'b0;
      total++; if (out_valid64 !== 1'b1 || imm64 !== exp_t[k] || tag_out64 !== 8'hA0 + 8'(k))
        begin bad++; $display("FAIL x64_%0d got v=%b imm=%h tag=%h exp imm=%h", k, out_valid64, imm64, tag_out64, exp_t[k]); end
`ifdef IMMGEN_ILLEGAL_TRAP_EN
      total++; if (illegal64 !== (k == 3)) begin bad++; $display("FAIL x64_ill%0d got=%b exp=%b", k, illegal64, (k == 3)); end
`else
      total++; if (illegal64 !== 1'b0) begin bad++; $display("FAIL x64_ill%0d got=%b exp=0", k, illegal64); end
`endif
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(32'h123450B7, 3'd4, 8'h77);
    cyc();
    tag = 8'h78;
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL rm_pre got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || imm !== 32'h0 || tag_out !== 8'h0 || illegal !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rm_async got v=%b imm=%h tag=%h ill=%b rdy=%b exp 0/0/0/0/1", out_valid, imm, tag_out, illegal, in_ready); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_after got v=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_xlen64();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts instruction bits [31:7] plus an immediate-select code through a valid/ready handshake, forms the sign- or zero-extended immediate for all RV32I/RV64I formats plus shift-amount and CSR-zimm forms, and presents it one cycle later through a 2-entry skid buffer. It carries a sideband tag so the decode pipeline can stall and flush without losing alignment.

## Interface
Parameters:
- XLEN, 32, immediate output width; legal values are 32 and 64.
- TAG_W, 8, width of the sideband tag carried alongside each immediate (for example rd index or a PC slice).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- flush_i  input  1  discards all buffered entries.
- in_valid_i  input  1  input entry valid.
- in_ready_o  output  1  block can accept an entry this cycle.
- instr_i  input  25  instruction bits [31:7]. Bit 0 of the port is instruction bit 7.
- imm_sel_i  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 I-shift, 110 CSR-zimm, 111 illegal.
- tag_i  input  TAG_W  sideband, passed through unchanged.
- out_valid_o  output  1  output entry valid.
- out_ready_i  input  1  consumer accepts the output entry.
- imm_o  output  XLEN  formed immediate.
- tag_o  output  TAG_W  tag of the output entry.
- illegal_o  output  1  output entry had sel 111 (see Configuration).

## Operation
Formation (combinational, before the register). `i` denotes instruction bit; `sx` sign-extends from i31 to XLEN.
- I: sx(i31:20).
- S: sx({i31:25, i11:7}).
- B: sx({i31, i7, i30:25, i11:8, 0}).
- J: sx({i31, i19:12, i20, i30:21, 0}).
- U: sx({i31:12, 12'b0}). Upper bits are sign-extended when XLEN=64.
- I-shift: zero-extend i[20 + log2(XLEN) - 1 : 20], so 5 bits for XLEN=32 and 6 bits for XLEN=64.
- CSR-zimm: zero-extend i19:15.
- 111: handled as defined under Configuration.

Buffer:
- Two entries, main and skid; each holds {imm, tag, illegal, valid}.
- Input handshake: an entry is accepted when in_valid_i && in_ready_o. in_ready_o = !skid_valid, driven from a register, with no combinational path from out_ready_i.
- Output handshake: an entry leaves when out_valid_o && out_ready_i. out_valid_o = main_valid, and the outputs come straight from the main register.
- Fill order: a new entry goes to main if main is empty or draining this cycle; otherwise it goes to skid.
- Drain: when main drains and skid is full, skid moves to main in the same edge.
- Order is strictly FIFO. No entry is ever duplicated or dropped, except by flush.

## Timing
- Reset values: out_valid_o=0, imm_o=0, tag_o=0, illegal_o=0, in_ready_o=1. Internal valids clear immediately on rst_ni low, asynchronously.
- Latency is 1 cycle: an entry accepted at edge N is visible at out_valid_o after edge N.
- Throughput is 1 entry per cycle while out_ready_i=1.
- With out_ready_i=0, two entries are accepted. in_ready_o falls after the edge that fills skid and rises after the edge that drains it.
- Simultaneous accept and drain with skid empty: the new entry replaces main and out_valid_o stays 1.
- flush_i=1: both valids clear at the next edge and in_ready_o=1. An input offered in the same cycle is dropped, and a same-cycle output handshake is still counted as consumed.
- Reset asserted mid-transfer: everything returns to the reset values and no partial entry survives.

## Configuration
- IMMGEN_ILLEGAL_TRAP_EN defined:
  - sel 111 produces imm_o=0 and illegal_o=1 for that entry.
  - Decode uses this flag to raise an illegal-instruction exception.
- Not defined:
  - sel 111 produces imm_o = sx(32'hDEADBEEF), which is 0xFFFFFFFFDEADBEEF for XLEN=64.
  - illegal_o is tied to 0.

## Test plan
- XLEN=32, I-type check: instr 0xFFF00093 (bits 31:7), sel 000, tag 0x5A, out_ready_i=1 -> one cycle later out_valid_o=1, imm_o=0xFFFFFFFF, tag_o=0x5A.
- B, U, shift and zimm formats:
  - 0xFE000EE3, sel 010 -> 0xFFFFFFFC.
  - 0x123450B7, sel 100 -> 0x12345000.
  - 0x00509093, sel 101 -> 0x5.
  - 0x000FD073, sel 110 -> 0x1F.
  - Issue the four back to back: outputs in order, one per cycle.
- Backpressure: hold out_ready_i=0 and offer three entries (tags 1, 2, 3) -> tags 1 and 2 accepted, in_ready_o=0 after the second accept, tag 3 held at the input. Then release out_ready_i -> tags emerge 1, 2, 3 with no gaps or duplicates.
- Flush: with main and skid both full, pulse flush_i together with in_valid_i -> next cycle out_valid_o=0 and in_ready_o=1; the same-cycle input never appears.
- XLEN=64 with IMMGEN_ILLEGAL_TRAP_EN defined:
  - I-type instr 0x80000013 -> imm_o=0xFFFFFFFFFFFFF800.
  - slli shamt 63 (0x03F09093) -> 0x3F.
  - sel 111 -> imm_o=0, illegal_o=1.
- Reset: assert rst_ni low mid-stream while out_valid_o=1 -> outputs go to the reset values immediately, without waiting for a clock edge.
